leaky_relu_derivative_array: RTL
================================

LEAKY_RELU_DERIVATIVE_ARRAY -- requirements
Module: leaky_relu_derivative_array

Interface
REQ-001 SHALL have parameter N, default 4, giving the lane count (N >= 1).
REQ-002 SHALL have parameter W, default 16, giving the signed two's-complement data width (W >= 4).
REQ-003 SHALL have parameter FRAC, default 8, giving the fractional bits of every fixed-point operand (0 <= FRAC < W).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-007 SHALL have port cfg_mode, input, 2 bits: 0 = leaky, 1 = plain ReLU, 2 = pass-through, 3 = reserved.
REQ-008 SHALL have port cfg_leak, input, W bits, signed: leak factor.
REQ-009 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a cfg write is rejected.
REQ-010 SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-011 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-012 SHALL have port in_mask, input, N bits: per-lane valid within the beat.
REQ-013 SHALL have port in_data, input, N x W bits, signed: upstream gradient, one word per lane.
REQ-014 SHALL have port in_h, input, N x W bits, signed: forward pre-activation H, one word per lane.
REQ-015 SHALL have port out_valid, output, 1 bit: an output beat is presented.
REQ-016 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-017 SHALL have port out_mask, output, N bits: the in_mask value carried with the beat.
REQ-018 SHALL have port out_data, output, N x W bits, signed: the per-lane results.
REQ-019 SHALL have port out_sat, output, N bits: per-lane flag that the result saturated.
REQ-020 SHALL have port busy, output, 1 bit: high while either pipeline stage holds a beat.
REQ-021 SHALL have port beat_count, output, 16 bits: number of output beats accepted downstream.

Function
REQ-022 SHALL transfer an input beat on a clock edge where in_valid and in_ready are both high, and an output beat on an edge where out_valid and out_ready are both high.
REQ-023 SHALL implement a two-stage pipeline: S1 registers the inputs and the lane compare; S2 registers the multiply, shift and saturation results.
REQ-024 SHALL give a latency of exactly 2 cycles from input transfer to out_valid when out_ready is held high, with a throughput of one beat per cycle.
REQ-025 SHALL define advance = !S2.valid || out_ready; S2 loads from S1 when advance is high; in_ready = !S1.valid || advance (combinational, no dependence on in_valid).
REQ-026 SHALL hold out_valid, out_data, out_mask and out_sat stable while out_valid is high and out_ready is low.
REQ-027 SHALL compute, per lane in mode 0: when H > 0 (strictly), result = data; otherwise result = sat_W((data * leak) >>> FRAC).
REQ-028 SHALL form the product at full 2W precision, apply an arithmetic right shift (floor), then clamp to [-2^(W-1), 2^(W-1)-1] and set out_sat for that lane when clamping occurs.
REQ-029 SHALL compute, in mode 1, result = data when H > 0, else 0.
REQ-030 SHALL compute, in mode 2, result = data unconditionally.
REQ-031 SHALL treat mode 3 as mode 0.
REQ-032 SHALL force result = 0 and out_sat = 0 for any lane whose mask bit is 0.
REQ-033 SHALL accept a beat with in_mask = 0; it passes through the pipeline normally.
REQ-034 SHALL latch cfg_mode and cfg_leak on a cfg_we edge only when busy is low and no input transfer occurs on that edge.
REQ-035 SHALL otherwise ignore the cfg write and pulse cfg_err high for the following cycle.
REQ-036 SHALL make a latched configuration apply to beats accepted on later edges; beats already in flight keep the configuration they entered with.
REQ-037 SHALL increment beat_count on each output transfer, saturating at 0xFFFF with no wrap.
REQ-038 SHALL keep the datapath a pure pipeline: no state other than the S1/S2 registers, the configuration registers, cfg_err and beat_count.

Reset
REQ-039 SHALL, while rst is low, asynchronously force: S1/S2 valid = 0, out_valid = 0, out_data = 0, out_mask = 0, out_sat = 0, cfg_err = 0, busy = 0, beat_count = 0, mode = 0, leak = 0.
REQ-040 SHALL drive in_ready high during reset and after reset release.
REQ-041 SHALL discard in-flight beats on reset mid-operation; no partial beat appears after release.
REQ-042 SHALL release reset so that the first input transfer may occur on the first rising clock edge after rst goes high.

Verification (N=4, W=16, FRAC=8)
REQ-043 SHALL cover: cfg mode 0, leak 0x0019; data lanes {0x0100, 0x0100, 0xFF00, 0x0200}, H {0x0001, 0x0000, 0xFF80, 0x0300}, mask 0xF -> out_data {0x0100, 0x0019, 0xFFE7, 0x0200}, out_sat 0x0 exactly 2 cycles later.
REQ-044 SHALL cover saturation: leak 0x7FFF, data 0x7FFF, H 0xFFFF -> result 0x7FFF with out_sat set; data 0x8000 with the same leak -> result 0x8000 with out_sat set.
REQ-045 SHALL cover back-pressure: hold out_ready low for 3 cycles while streaming -> output held stable, in_ready low once S1 and S2 are full, no beat lost or duplicated, beat_count correct.
REQ-046 SHALL cover a cfg write while busy is high -> cfg_err pulses for 1 cycle and the old mode and leak remain in effect; the same write while idle -> accepted, no cfg_err.
REQ-047 SHALL cover reset asserted with 2 beats in flight -> out_valid = 0 and beat_count = 0 immediately, with no stale beat after release.
REQ-048 SHALL cover mode 1 and mode 2 with mask 0x5 -> lanes 1 and 3 are 0, and lanes 0 and 2 follow the mode rule.

Source files
------------

// File: rtl/leaky_relu_derivative_array.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// leaky_relu_derivative_array
//
// Backward pass of a leaky-ReLU activation across N parallel lanes. Each lane
// takes an upstream gradient word (in_data) and the forward pre-activation (H).
// It produces the gradient scaled by the activation derivative:
//   mode 0/3 (leaky) : H > 0 ? data : sat((data * leak) >>> FRAC)
//   mode 1 (ReLU)    : H > 0 ? data : 0
//   mode 2 (pass)    : data
// A lane whose mask bit is clear always yields 0 with no saturation flag.
//
// The pipeline has two stages with valid/ready handshakes on both sides.
//   S1 : captures the inputs, the per-lane "H > 0" compare and the active
//        configuration, so a beat keeps the configuration it entered with.
//   S2 : captures the multiply / shift / clamp result that drives the outputs.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   cfg_we            configuration write strobe
//   cfg_mode/cfg_leak mode select and signed fixed-point leak factor
//   cfg_err           one-cycle pulse after a rejected configuration write
//   in_valid/in_ready input handshake; in_mask/in_data/in_h per-lane words
//   out_valid/out_ready output handshake; out_mask/out_data/out_sat per lane
//   busy              either pipeline stage holds a beat
//   beat_count        saturating count of output beats accepted downstream
// -----------------------------------------------------------------------------
module leaky_relu_derivative_array #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_mode,
  input  logic signed [W-1:0]   cfg_leak,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_mask,
  input  logic signed [N*W-1:0] in_data,
  input  logic signed [N*W-1:0] in_h,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_mask,
  output logic signed [N*W-1:0] out_data,
  output logic [N-1:0]          out_sat,
  output logic                  busy,
  output logic [15:0]           beat_count
);

  typedef enum logic [1:0] {
    MODE_LEAKY = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_PASS  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int W2 = 2 * W;

  // Clamp limits of a W-bit signed word, expressed at product width.
  localparam logic signed [W2-1:0] SAT_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};

  // Per-lane result: {saturated, W-bit value}. A masked lane returns all zero.
  function automatic logic [W:0] lane_calc(
    input mode_e                mode,
    input logic signed [W-1:0]  leak,
    input logic signed [W-1:0]  d,
    input logic                 pos,
    input logic                 en
  );
    logic signed [W2-1:0] prod;
    logic signed [W2-1:0] shifted;
    logic [W:0]           res;
    prod    = W2'(d) * W2'(leak);
    // Arithmetic shift floors toward negative infinity.
    shifted = prod >>> FRAC;
    res     = {(W + 1){1'b0}};
    if (!en) begin
      res = {(W + 1){1'b0}};
    end else begin
      case (mode)
        MODE_RELU: begin
          if (pos) begin
            res = {1'b0, d};
          end else begin
            res = {(W + 1){1'b0}};
          end
        end
        MODE_PASS: begin
          res = {1'b0, d};
        end
        default: begin
          // Leaky path; the reserved mode behaves the same way.
          if (pos) begin
            res = {1'b0, d};
          end else if (shifted > SAT_MAX) begin
            res = {1'b1, SAT_MAX[W-1:0]};
          end else if (shifted < SAT_MIN) begin
            res = {1'b1, SAT_MIN[W-1:0]};
          end else begin
            res = {1'b0, shifted[W-1:0]};
          end
        end
      endcase
    end
    return res;
  endfunction

  // Configuration registers.
  mode_e                mode_r;
  logic signed [W-1:0]  leak_r;
  logic                 cfg_err_r;

  // Stage 1 registers.
  logic                 s1_valid_r;
  logic [N-1:0]         s1_mask_r;
  logic [N*W-1:0]       s1_data_r;
  logic [N-1:0]         s1_pos_r;
  mode_e                s1_mode_r;
  logic signed [W-1:0]  s1_leak_r;

  // Stage 2 registers; these are the outputs.
  logic                 s2_valid_r;
  logic [N-1:0]         s2_mask_r;
  logic [N*W-1:0]       s2_data_r;
  logic [N-1:0]         s2_sat_r;

  logic [15:0]          beat_count_r;

  // Handshake and datapath combinational signals.
  logic                 advance_s;
  logic                 in_ready_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 busy_s;
  logic                 cfg_ok_s;
  logic [N-1:0]         h_pos_s;
  logic [N*W-1:0]       res_data_s;
  logic [N-1:0]         res_sat_s;

  // Handshake decode. in_ready looks only at the pipeline state and out_ready.
  always_comb begin
    advance_s  = !s2_valid_r || out_ready;
    in_ready_s = !s1_valid_r || advance_s;
    in_fire_s  = in_valid && in_ready_s;
    out_fire_s = s2_valid_r && out_ready;
    busy_s     = s1_valid_r || s2_valid_r;
    // A write is only safe while the pipeline is empty and no beat enters.
    cfg_ok_s   = cfg_we && !busy_s && !in_fire_s;
  end

  // Lane compare H > 0: sign bit clear and value non-zero.
  always_comb begin
    h_pos_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      h_pos_s[i] = !in_h[i*W + W - 1] && (in_h[i*W +: W] != {W{1'b0}});
    end
  end

  // Per-lane multiply, shift and clamp on the stage-1 contents.
  always_comb begin
    res_data_s = {(N * W){1'b0}};
    res_sat_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      {res_sat_s[i], res_data_s[i*W +: W]} =
        lane_calc(s1_mode_r, s1_leak_r, s1_data_r[i*W +: W], s1_pos_r[i], s1_mask_r[i]);
    end
  end

  // Configuration registers and the rejected-write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= MODE_LEAKY;
      leak_r    <= {W{1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !cfg_ok_s;
      if (cfg_ok_s) begin
        mode_r <= mode_e'(cfg_mode);
        leak_r <= cfg_leak;
      end
    end
  end

  // Stage 1: capture inputs, lane compare and the configuration of this beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_mask_r  <= {N{1'b0}};
      s1_data_r  <= {(N * W){1'b0}};
      s1_pos_r   <= {N{1'b0}};
      s1_mode_r  <= MODE_LEAKY;
      s1_leak_r  <= {W{1'b0}};
    end else if (in_ready_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_mask_r <= in_mask;
        s1_data_r <= in_data;
        s1_pos_r  <= h_pos_s;
        s1_mode_r <= mode_r;
        s1_leak_r <= leak_r;
      end
    end
  end

  // Stage 2: capture the lane results; held while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_r <= 1'b0;
      s2_mask_r  <= {N{1'b0}};
      s2_data_r  <= {(N * W){1'b0}};
      s2_sat_r   <= {N{1'b0}};
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_mask_r <= s1_mask_r;
        s2_data_r <= res_data_s;
        s2_sat_r  <= res_sat_s;
      end
    end
  end

  // Output beat counter, sticks at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count_r <= 16'h0000;
    end else if (out_fire_s && (beat_count_r != 16'hFFFF)) begin
      beat_count_r <= beat_count_r + 16'h0001;
    end
  end

  assign in_ready   = in_ready_s;
  assign busy       = busy_s;
  assign cfg_err    = cfg_err_r;
  assign out_valid  = s2_valid_r;
  assign out_mask   = s2_mask_r;
  assign out_data   = s2_data_r;
  assign out_sat    = s2_sat_r;
  assign beat_count = beat_count_r;

endmodule
